// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan driver.
package seg_pkg;

    localparam int DIGIT_W         = 4;
    localparam int NUM_DIGITS_DEF  = 8;
    localparam int TICK_PERIOD_DEF = 100000;
    localparam int IDX_W_DEF       = $clog2(NUM_DIGITS_DEF);

    // Scan index sized for the default (and maximum) digit count.
    typedef logic [IDX_W_DEF-1:0] idx_t;

endpackage

// File: rtl/seg_scan_tick_gen.sv
// Prescaler: counts 0..PERIOD-1 and asserts tick during the last count.
module tick_gen
    import seg_pkg::*;
#(
    parameter int PERIOD = TICK_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero after the terminal count.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scan driver for common-anode 7-segment digits with a
// double-buffered frame so a digit never shows a half-updated value.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int TICK_PERIOD = TICK_PERIOD_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [DIGIT_W-1:0]            hex,
    output logic                          dp_n,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = DIGIT_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    logic tick;

    tick_gen #(.PERIOD(TICK_PERIOD)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         stg_data_q, stg_data_d;
    logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d;
    logic [NUM_DIGITS-1:0] stg_en_q, stg_en_d;
    logic [DW-1:0]         disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0] disp_en_q, disp_en_d;
    logic                  pending_q, pending_d;
    logic [DIGIT_W-1:0]    hex_q, hex_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_start_q, frame_start_d;
    logic                  boundary;

    // Scan index, double-buffer transfer and output selection.
    always_comb begin
        boundary = tick && (idx_q == IDX_LAST);

        idx_d = idx_q;
        if (tick) idx_d = boundary ? '0 : idx_q + 1'b1;

        stg_data_d  = stg_data_q;
        stg_dp_d    = stg_dp_q;
        stg_en_d    = stg_en_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        disp_en_d   = disp_en_q;
        pending_d   = pending_q;

        if (load) begin
            // Staging always takes the newest inputs; on a frame boundary
            // they also go straight to the display and nothing stays pending.
            stg_data_d = data;
            stg_dp_d   = dp_in;
            stg_en_d   = digit_en;
            if (boundary) begin
                disp_data_d = data;
                disp_dp_d   = dp_in;
                disp_en_d   = digit_en;
                pending_d   = 1'b0;
            end else begin
                pending_d   = 1'b1;
            end
        end else if (boundary && pending_q) begin
            disp_data_d = stg_data_q;
            disp_dp_d   = stg_dp_q;
            disp_en_d   = stg_en_q;
            pending_d   = 1'b0;
        end

        // Outputs follow the post-update index so they switch with idx.
        hex_d         = disp_data_d[DIGIT_W*int'(idx_d) +: DIGIT_W];
        dp_n_d        = ~disp_dp_d[idx_d];
        an_d          = disp_en_d[idx_d] ? ~(AN_ONE << idx_d) : '1;
        frame_start_d = boundary;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q         <= '0;
            stg_data_q    <= '0;
            stg_dp_q      <= '0;
            stg_en_q      <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            disp_en_q     <= '0;
            pending_q     <= 1'b0;
            hex_q         <= '0;
            dp_n_q        <= 1'b1;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            stg_data_q    <= stg_data_d;
            stg_dp_q      <= stg_dp_d;
            stg_en_q      <= stg_en_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            disp_en_q     <= disp_en_d;
            pending_q     <= pending_d;
            hex_q         <= hex_d;
            dp_n_q        <= dp_n_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hex         = hex_q;
    assign dp_n        = dp_n_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a cycle-count reference model pushes the
// expected outputs after each edge; a monitor pops and compares them.
module tb_seg_scan;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int NP = N * P;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           load = 1'b0;
    logic [4*N-1:0] data = '0;
    logic [N-1:0]   dp_in = '0;
    logic [N-1:0]   digit_en = '0;
    logic [3:0]     hex;
    logic           dp_n;
    logic [N-1:0]   an;
    logic           frame_start;

    seg_scan #(.NUM_DIGITS(N), .TICK_PERIOD(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .data        (data),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .hex         (hex),
        .dp_n        (dp_n),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   hex;
        logic         dp_n;
        logic [N-1:0] an;
        logic         fs;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: k = edges since reset; digit = (k / P) mod N.
    int             k = 0;
    logic [4*N-1:0] m_stg_data = '0, m_disp_data = '0;
    logic [N-1:0]   m_stg_dp = '0, m_disp_dp = '0, m_stg_en = '0, m_disp_en = '0;
    bit             m_pending = 0;

    always @(posedge clk) begin
        exp_t e;
        bit   bnd;
        int   d;
        bnd = 0;
        if (reset) begin
            k = 0;
            m_stg_data = '0; m_stg_dp = '0; m_stg_en = '0;
            m_disp_data = '0; m_disp_dp = '0; m_disp_en = '0;
            m_pending = 0;
        end else begin
            k = k + 1;
            bnd = (k % NP) == 0;
            if (load) begin
                m_stg_data = data; m_stg_dp = dp_in; m_stg_en = digit_en;
                if (bnd) begin
                    m_disp_data = data; m_disp_dp = dp_in; m_disp_en = digit_en;
                    m_pending = 0;
                end else begin
                    m_pending = 1;
                end
            end else if (bnd && m_pending) begin
                m_disp_data = m_stg_data; m_disp_dp = m_stg_dp; m_disp_en = m_stg_en;
                m_pending = 0;
            end
        end
        d      = (k / P) % N;
        e.hex  = 4'((m_disp_data >> (4 * d)) & 16'hF);
        e.dp_n = !m_disp_dp[d];
        e.an   = '1;
        if (m_disp_en[d]) e.an[d] = 1'b0;
        e.fs   = bnd;
        exp_q.push_back(e);
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s k=%0d t=%0t got=%0h want=%0h", nm, k, $time, act, req);
        end
    endtask

    // Monitor: outputs are registered, so sample on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hex", int'(hex), int'(e.hex));
            chk("dp_n", int'(dp_n), int'(e.dp_n));
            chk("an", int'(an), int'(e.an));
            chk("frame_start", int'(frame_start), int'(e.fs));
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Advance until the model's frame phase matches, with a cycle bound.
    task automatic wait_phase(input int ph);
        int budget;
        budget = 4 * NP;
        while ((k % NP) != ph && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if ((k % NP) != ph) begin
            errors++;
            $display("FAIL wait_phase got=%0d want=%0d", k % NP, ph);
        end
    endtask

    task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] dp, input logic [N-1:0] en);
        load = 1'b1; data = d; dp_in = dp; digit_en = en;
        step();
        load = 1'b0; data = $urandom(); dp_in = N'($urandom()); digit_en = N'($urandom());
    endtask

    initial begin
        // Reset for 3 cycles, then an idle blank display.
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(40);

        // Load during digit 1; shows from the next frame start.
        wait_phase(5);
        do_load(16'h4321, 4'b0100, 4'hF);
        step(2 * NP);

        // Two loads in one frame: the last wins.
        wait_phase(2);
        do_load(16'hAAAA, 4'b0000, 4'hF);
        step(3);
        do_load(16'hBEEF, 4'b0000, 4'hF);
        step(2 * NP);

        // Load on the boundary cycle goes straight to the display.
        wait_phase(NP - 1);
        do_load(16'h00C5, 4'b0001, 4'hF);
        step(2 * NP);

        // Partial digit enable.
        do_load(16'h9876, 4'b1010, 4'b0101);
        step(2 * NP + 3);

        // Reset mid-digit 2 with a load pending.
        wait_phase(9);
        do_load(16'h1234, 4'b1111, 4'hF);
        step();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(3 * NP);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 2));
                reset = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                do_load(16'($urandom()), N'($urandom()), N'($urandom()));
            end else begin
                step();
            end
        end

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
